sram_port_arbiter: RTL
======================

# sram_port_arbiter

Two-master arbiter that shares one synchronous single-port `sram` (1-cycle read latency, byte-enable writes) between the pipeline's instruction-fetch port and data-access port. It sits between `mycpu_pipeline` and a unified `sram`, replacing the split inst/data SRAM pair. It grants one request per cycle, routes read data back to the correct master, and drives the pipeline's `stallreq_axi` when a request loses arbitration. Data accesses have priority, with a starvation guard for fetch.

## Interface
- `STARVE_MAX`, default 4: maximum consecutive data grants while fetch is pending before fetch is forced through; legal range 1..15.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `inst_req`  in  1  fetch request; held with its address until granted
- `inst_we`  in  8  fetch byte write enables; 0 means read
- `inst_addr`  in  64  fetch address
- `inst_wdata`  in  64  fetch write data
- `inst_gnt`  out  1  fetch accepted this cycle
- `inst_rvalid`  out  1  fetch read data valid
- `inst_rdata`  out  64  fetch read data
- `data_req`, `data_we`, `data_addr`, `data_wdata`, `data_gnt`, `data_rvalid`, `data_rdata`: same directions, widths and meanings as the fetch set, for the data port
- `sram_en`  out  1  SRAM enable
- `sram_we`  out  8  SRAM byte write enables
- `sram_addr`  out  64  SRAM address
- `sram_wdata`  out  64  SRAM write data
- `sram_rdata`  in  64  SRAM read data, valid one cycle after `sram_en` with `sram_we == 0`
- `stallreq`  out  1  asserted when any request goes ungranted this cycle

## Operation
- Grant is combinational: at most one of `inst_gnt`/`data_gnt` per cycle, and a grant is given only to a requester that is asserting its request.
- Only one request: that request is granted.
- Both requests: `data` is granted, unless `starve_cnt == STARVE_MAX`, in which case `inst` is granted.
- `starve_cnt` (width 4) increments on each data grant while `inst_req` is high, and saturates at `STARVE_MAX`. It clears on any inst grant, and on any cycle with `inst_req` low.
- The SRAM mux selects the granted master's `we/addr/wdata`. `sram_en` equals `inst_gnt | data_gnt`. With no grant, `sram_we`, `sram_addr` and `sram_wdata` are 0.
- Response tracking uses registers `resp_owner` (NONE/INST/DATA) and `resp_pending`. A granted read (`we == 0`) sets these for the next cycle. Writes set `resp_owner = NONE`.
- Cycle after a read grant: the owner's `rvalid` is 1 and its `rdata` equals `sram_rdata`. The non-owner's `rdata` is 0.
- `stallreq` = `(inst_req & ~inst_gnt) | (data_req & ~data_gnt)`.
- Back-to-back grants every cycle are supported. A new grant in the same cycle as a response is legal.

## Timing
- Reset (`rst_n` low, asynchronous): `resp_owner = NONE`, `starve_cnt = 0`. While in reset, all outputs are 0: gnts, rvalids, rdatas, `sram_*`, `stallreq`.
- Reset mid-operation: an outstanding read response is discarded, and no `rvalid` appears after release.
- Grant latency: 0 cycles from the request.
- Read latency: `rvalid` exactly 1 cycle after the grant. Writes produce no `rvalid`.
- Worst-case fetch wait under continuous data traffic: `STARVE_MAX` cycles.
- Simultaneous events: a new request in the response cycle does not affect the response routing.

## Structure
- Shared package `sram_arb_pkg`:
  - owner encoding `OWN_NONE = 2'd0`, `OWN_INST = 2'd1`, `OWN_DATA = 2'd2`
  - counter width constant `STARVE_W = 4`
- Natural sub-module `sram_arb_pick`: combinational two-way priority picker with starvation override. Inputs are `inst_req`, `data_req` and `force_inst`; outputs are the two grants.
- Response registers and the starvation counter remain in the top module.

## Test plan
- **Reset:** hold `rst_n = 0` with both requests high → all outputs are 0. Release → grant is given in the same cycle.
- **Fetch read alone:** `inst_req = 1`, `inst_addr = 0x80000000`, SRAM returns `0x00000013` → `inst_gnt = 1` in cycle 0; `inst_rvalid = 1` and `inst_rdata = 0x13` in cycle 1; `stallreq = 0` throughout.
- **Conflict:** both requests issued in cycle 0, data read of `0x80001000` → `data_gnt = 1`, `stallreq = 1`. Cycle 1: `inst_gnt = 1` and `data_rvalid = 1`.
- **Starvation:** both requests held high continuously, `STARVE_MAX = 4` → data is granted in cycles 0–3, inst in cycle 4, data in cycle 5.
- **Write:** data write with `we = 0xFF`, `wdata = 0xDEADBEEF` → `sram_we = 0xFF`; no `rvalid` in the next cycle.
- **Reset during response:** read granted, then `rst_n` asserted before the next edge → no `rvalid` after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the unified SRAM arbiter.
// Owner encoding for read responses and the starvation counter width.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-way priority picker: data wins unless force_inst is set.
// In: inst_req, data_req, force_inst. Out: inst_gnt, data_gnt.
module sram_arb_pick (
    input  logic inst_req,
    input  logic data_req,
    input  logic force_inst,
    output logic inst_gnt,
    output logic data_gnt
);

    always_comb begin
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        priority case (1'b1)
            (inst_req & (force_inst | ~data_req)): inst_gnt = 1'b1;
            data_req:                              data_gnt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency SRAM between fetch and data masters.
// Ports: inst_*/data_* master sides, sram_* memory side, stallreq.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_req,
    input  logic [7:0]  inst_we,
    input  logic [63:0] inst_addr,
    input  logic [63:0] inst_wdata,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [63:0] inst_rdata,
    input  logic        data_req,
    input  logic [7:0]  data_we,
    input  logic [63:0] data_addr,
    input  logic [63:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [63:0] data_rdata,
    output logic        sram_en,
    output logic [7:0]  sram_we,
    output logic [63:0] sram_addr,
    output logic [63:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    output logic        stallreq
);

    localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    owner_e              resp_owner;
    logic                resp_pending;
    logic                pick_inst;
    logic                pick_data;
    logic                force_inst;
    logic                rd_grant;
    owner_e              nxt_owner;

    assign force_inst = (starve_cnt == SMAX);

    sram_arb_pick u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .force_inst (force_inst),
        .inst_gnt   (pick_inst),
        .data_gnt   (pick_data)
    );

    // Everything combinational is held at 0 while reset is asserted.
    assign inst_gnt = rst_n & pick_inst;
    assign data_gnt = rst_n & pick_data;
    assign sram_en  = inst_gnt | data_gnt;
    assign stallreq = rst_n &
                      ((inst_req & ~inst_gnt) |
                       (data_req & ~data_gnt));

    always_comb begin
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        rd_grant   = 1'b0;
        nxt_owner  = OWN_NONE;
        if (inst_gnt) begin
            sram_we    = inst_we;
            sram_addr  = inst_addr;
            sram_wdata = inst_wdata;
            rd_grant   = (inst_we == 8'd0);
            nxt_owner  = rd_grant ? OWN_INST : OWN_NONE;
        end else if (data_gnt) begin
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            rd_grant   = (data_we == 8'd0);
            nxt_owner  = rd_grant ? OWN_DATA : OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner   <= OWN_NONE;
            resp_pending <= 1'b0;
        end else begin
            resp_owner   <= nxt_owner;
            resp_pending <= rd_grant;
        end
    end

    // Counts data wins over a waiting fetch; saturates to force fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!inst_req || inst_gnt) begin
            starve_cnt <= '0;
        end else if (data_gnt && starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign inst_rvalid = rst_n & resp_pending &
                         (resp_owner == OWN_INST);
    assign data_rvalid = rst_n & resp_pending &
                         (resp_owner == OWN_DATA);
    assign inst_rdata  = inst_rvalid ? sram_rdata : '0;
    assign data_rdata  = data_rvalid ? sram_rdata : '0;

endmodule
